inv_shift_sub_round: RTL

- Upstream neighbour of the decryption column-mix/key-add stage. Performs one inverse-cipher round's InvShiftRows followed by InvSubBytes on a 128-bit state.
- Output block and forwarded round key feed the key-add/inverse-column-mix stage directly.
- Substitution is time-multiplexed: LANES inverse S-box copies process the state over 16/LANES cycles, trading area for throughput.
- Uses a valid/ready handshake on both sides.

---
 rtl/inv_shift_sub_round.sv | 104 ++++++++++
 1 files changed

// File: rtl/inv_shift_sub_round.sv
// rtl/inv_shift_sub_round.sv - InvShiftRows at capture, then InvSubBytes over 16/LANES cycles
module inv_shift_sub_round #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] iBlockIn,
    input  logic [127:0] iKeyValue,
    input  logic         iValid,
    output logic         oReady,
    output logic [127:0] oBlockOut,
    output logic [127:0] oKeyValue,
    output logic         oValid,
    input  logic         iReady
);

    localparam int N  = 16 / LANES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [127:0]    r_block;
    logic [127:0]    r_key;
    logic [IW-1:0]   r_idx;
    logic            r_live;
    logic [127:0]    w_shifted;
    logic [127:0]    w_sub;
    logic            w_accept;

    // Row r rotates right by r columns: out[r][c] = in[r][(c-r) mod 4].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_shifted[127-8*(4*c+r) -: 8] = iBlockIn[127-8*(4*((c-r+4)%4)+r) -: 8];
        end
    end

    always_comb begin
        w_sub = r_block;
        for (int l = 0; l < LANES; l++) begin
            w_sub[127-8*(int'(r_idx)*LANES+l) -: 8] = INV_SBOX[r_block[127-8*(int'(r_idx)*LANES+l) -: 8]];
        end
    end

    // r_live holds oReady low until the first edge after reset release.
    assign w_accept = (r_state == IDLE) && r_live && iValid;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = BUSY;
            BUSY:    if (r_idx == IW'(N-1)) w_next = DONE;
            DONE:    if (iReady) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_block <= '0;
            r_key   <= '0;
            r_idx   <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next;
            if (w_accept) begin
                r_block <= w_shifted;
                r_key   <= iKeyValue;
                r_idx   <= '0;
            end else if (r_state == BUSY) begin
                r_block <= w_sub;
                r_idx   <= r_idx + IW'(1);
            end
        end
    end

    assign oReady    = (r_state == IDLE) && r_live;
    assign oValid    = (r_state == DONE);
    assign oBlockOut = r_block;
    assign oKeyValue = r_key;

endmodule
